// File: rtl/execute_mem_pkg.sv
// Shared memory-pipe definitions: width codes, store-queue entry and the
// strobe/data replication used by the store queue and post-commit buffer.
package execute_mem_pkg;

   localparam int SQ_ADDR_W = 32;
   localparam int NUM_LANES = 4;

   localparam logic [1:0] LSWIDTH_BYTE = 2'b00;
   localparam logic [1:0] LSWIDTH_HALF = 2'b01;
   localparam logic [1:0] LSWIDTH_WORD = 2'b10;

   typedef struct packed {
      logic [SQ_ADDR_W-1:0] addr;
      logic [NUM_LANES-1:0] strb;
      logic [1:0]           lswidth;
      logic [31:0]          data;
      logic                 uncached;
   } sq_entry_t;

   typedef struct packed {
      logic [NUM_LANES-1:0] strb;
      logic [31:0]          data;
   } sq_lane_t;

   // Reserved width code 11 falls into the word case.
   function automatic sq_lane_t sq_replicate(input logic [1:0]  lswidth,
                                             input logic [1:0]  alo,
                                             input logic [31:0] d);
      sq_lane_t r;
      case (lswidth)
         LSWIDTH_BYTE: begin
            r.strb = 4'b0001 << alo;
            r.data = {4{d[7:0]}};
         end
         LSWIDTH_HALF: begin
            r.strb = alo[1] ? 4'b1100 : 4'b0011;
            r.data = {2{d[15:0]}};
         end
         default: begin
            r.strb = 4'b1111;
            r.data = d;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/execute_mem_storequeue_if.sv
// Store-queue bus: enqueue, commit, flush, drain handshake and forwarding query.
interface execute_mem_storequeue_if #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32
);
   logic                     bco_valid;
   logic                     enq_valid;
   logic                     enq_ready;
   logic [ADDR_W-1:0]        enq_addr;
   logic [1:0]               enq_lswidth;
   logic [31:0]              enq_data;
   logic                     enq_uncached;
   logic                     cmt_en;
   logic                     cmt_valid;
   logic                     drain_valid;
   logic                     drain_ready;
   logic [ADDR_W-1:0]        drain_addr;
   logic [3:0]               drain_strb;
   logic [1:0]               drain_lswidth;
   logic [31:0]              drain_data;
   logic                     drain_uncached;
   logic [ADDR_W-1:0]        q_addr;
   logic [3:0]               qout_strb;
   logic [31:0]              qout_data;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output bco_valid, enq_valid, enq_addr, enq_lswidth, enq_data, enq_uncached,
             cmt_en, drain_ready, q_addr,
      input  enq_ready, cmt_valid, drain_valid, drain_addr, drain_strb, drain_lswidth,
             drain_data, drain_uncached, qout_strb, qout_data, count
   );

   modport slave (
      input  bco_valid, enq_valid, enq_addr, enq_lswidth, enq_data, enq_uncached,
             cmt_en, drain_ready, q_addr,
      output enq_ready, cmt_valid, drain_valid, drain_addr, drain_strb, drain_lswidth,
             drain_data, drain_uncached, qout_strb, qout_data, count
   );
endinterface

// File: rtl/execute_mem_sq_fwd.sv
// Age-ordered youngest-match byte selector for store-to-load forwarding.
// Only built when EXECUTE_MEM_SQ_FORWARD_EN is defined.
`ifdef EXECUTE_MEM_SQ_FORWARD_EN
module execute_mem_sq_fwd
   import execute_mem_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32
) (
   input  sq_entry_t [DEPTH-1:0]            ents_i,
   input  logic [$clog2(DEPTH):0]           head_i,
   input  logic [$clog2(DEPTH):0]           tail_i,
   input  logic [ADDR_W-1:0]                q_addr_i,
   output logic [NUM_LANES-1:0]             strb_o,
   output logic [NUM_LANES-1:0][7:0]        data_o
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0]              occ;
   logic [SQ_ADDR_W-1:0]       qa;
   logic [DEPTH-1:0]           hit;
   logic [DEPTH-1:0][IW-1:0]   ord;
   logic                       unused_bits;

   assign occ = tail_i - head_i;
   assign qa  = SQ_ADDR_W'(q_addr_i);

   // ord[g] is the g-th oldest slot; hit only for live, cached, same-word entries.
   for (genvar g = 0; g < DEPTH; g++) begin : g_age
      assign ord[g] = head_i[IW-1:0] + IW'(g);
      assign hit[g] = (PW'(g) < occ) && !ents_i[ord[g]].uncached &&
                      (ents_i[ord[g]].addr[SQ_ADDR_W-1:2] == qa[SQ_ADDR_W-1:2]);
   end

   // Younger matches overwrite older ones as the scan walks forward in age.
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic       ls;
      logic [7:0] ld;
      always_comb begin
         ls = 1'b0;
         ld = '0;
         for (int g = 0; g < DEPTH; g++) begin
            if (hit[g] && ents_i[ord[g]].strb[l]) begin
               ls = 1'b1;
               ld = ents_i[ord[g]].data[8*l +: 8];
            end
         end
      end
      assign strb_o[l] = ls;
      assign data_o[l] = ld;
   end

   always_comb begin
      unused_bits = ^qa[1:0];
      for (int i = 0; i < DEPTH; i++)
         unused_bits = unused_bits ^ (^{ents_i[i].lswidth, ents_i[i].addr[1:0]});
   end

endmodule
`endif

// File: rtl/execute_mem_storequeue.sv
// In-order speculative store queue with commit pointer, drain handshake and
// flush. EXECUTE_MEM_SQ_FORWARD_EN adds registered store-to-load forwarding.
module execute_mem_storequeue
   import execute_mem_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   execute_mem_storequeue_if.slave  sq
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0]          head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
   logic [PW-1:0]          occ;
   sq_entry_t [DEPTH-1:0]  ent_q;
   sq_entry_t              enq_ent, drn_ent;
   sq_lane_t               enq_lane;
   logic                   do_enq, do_cmt, do_drn;

   assign occ             = tail_q - head_q;
   assign sq.count        = occ;
   assign sq.enq_ready    = (occ != PW'(DEPTH));
   assign sq.cmt_valid    = (cptr_q != tail_q);
   assign sq.drain_valid  = (head_q != cptr_q);

   assign drn_ent           = ent_q[head_q[IW-1:0]];
   assign sq.drain_addr     = ADDR_W'(drn_ent.addr);
   assign sq.drain_strb     = drn_ent.strb;
   assign sq.drain_lswidth  = drn_ent.lswidth;
   assign sq.drain_data     = drn_ent.data;
   assign sq.drain_uncached = drn_ent.uncached;

   always_comb begin
      enq_lane = sq_replicate(sq.enq_lswidth, sq.enq_addr[1:0], sq.enq_data);
      enq_ent  = '{addr:     SQ_ADDR_W'(sq.enq_addr),
                   strb:     enq_lane.strb,
                   lswidth:  sq.enq_lswidth,
                   data:     enq_lane.data,
                   uncached: sq.enq_uncached};
   end

   // A flush rewinds tail to the post-commit cptr, so a same-cycle enqueue is lost.
   always_comb begin
      do_enq = sq.enq_valid & sq.enq_ready & ~sq.bco_valid;
      do_cmt = sq.cmt_en & sq.cmt_valid;
      do_drn = sq.drain_valid & sq.drain_ready;
      head_d = head_q + PW'(do_drn);
      cptr_d = cptr_q + PW'(do_cmt);
      tail_d = sq.bco_valid ? cptr_d : tail_q + PW'(do_enq);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q <= '0;
         cptr_q <= '0;
         tail_q <= '0;
         ent_q  <= '0;
      end else begin
         head_q <= head_d;
         cptr_q <= cptr_d;
         tail_q <= tail_d;
         if (do_enq) ent_q[tail_q[IW-1:0]] <= enq_ent;
      end
   end

`ifdef EXECUTE_MEM_SQ_FORWARD_EN
   logic [NUM_LANES-1:0]        fwd_strb, qstrb_q;
   logic [NUM_LANES-1:0][7:0]   fwd_data, qdata_q;

   execute_mem_sq_fwd #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fwd (
      .ents_i   (ent_q),
      .head_i   (head_q),
      .tail_i   (tail_q),
      .q_addr_i (sq.q_addr),
      .strb_o   (fwd_strb),
      .data_o   (fwd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         qstrb_q <= '0;
         qdata_q <= '0;
      end else begin
         qstrb_q <= fwd_strb;
         qdata_q <= fwd_data;
      end
   end

   assign sq.qout_strb = qstrb_q;
   assign sq.qout_data = qdata_q;
`else
   logic unused_qaddr;
   assign unused_qaddr = ^sq.q_addr;
   assign sq.qout_strb = '0;
   assign sq.qout_data = '0;
`endif

endmodule

// File: tb/tb_execute_mem_storequeue.sv
// Directed bench for execute_mem_storequeue: replication table, full/flush,
// forwarding and a pointer-wrap run against a small order model.
module tb_execute_mem_storequeue;
   import execute_mem_pkg::*;

   localparam int DEPTH = 8;
`ifdef EXECUTE_MEM_SQ_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   execute_mem_storequeue_if #(.DEPTH(DEPTH), .ADDR_W(32)) sq ();

   execute_mem_storequeue #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .sq    (sq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  strb;
      logic [31:0] data;
   } vec_t;

   vec_t        tbl[7];
   logic [31:0] mdl[$];
   int          ncmt;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sq.bco_valid    = 1'b0;
      sq.enq_valid    = 1'b0;
      sq.enq_addr     = '0;
      sq.enq_lswidth  = LSWIDTH_WORD;
      sq.enq_data     = '0;
      sq.enq_uncached = 1'b0;
      sq.cmt_en       = 1'b0;
      sq.drain_ready  = 1'b0;
      sq.q_addr       = '0;
   endtask

   task automatic set_enq(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
      sq.enq_valid   = 1'b1;
      sq.enq_lswidth = w;
      sq.enq_addr    = a;
      sq.enq_data    = d;
   endtask

   task automatic drain_one(input string nm, input logic [31:0] exp);
      chk({nm, "_dv"}, sq.drain_valid, 1'b1);
      chk({nm, "_data"}, sq.drain_data, exp);
      sq.drain_ready = 1'b1;
      tick();
      sq.drain_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{LSWIDTH_BYTE, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5};
      tbl[1] = '{LSWIDTH_BYTE, 32'h0000_1000, 32'hFFFF_FF3C, 4'b0001, 32'h3C3C_3C3C};
      tbl[2] = '{LSWIDTH_BYTE, 32'h0000_0001, 32'h0000_0077, 4'b0010, 32'h7777_7777};
      tbl[3] = '{LSWIDTH_HALF, 32'h0000_2002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF};
      tbl[4] = '{LSWIDTH_HALF, 32'h0000_2000, 32'h0000_5566, 4'b0011, 32'h5566_5566};
      tbl[5] = '{LSWIDTH_WORD, 32'h0000_2000, 32'h1122_3344, 4'b1111, 32'h1122_3344};
      tbl[6] = '{2'b11,        32'h0000_0004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};

      idle();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();

      chk("rst_count", sq.count, 0);
      chk("rst_enq_ready", sq.enq_ready, 1);
      chk("rst_cmt_valid", sq.cmt_valid, 0);
      chk("rst_drain_valid", sq.drain_valid, 0);
      chk("rst_drain_strb", sq.drain_strb, 0);
      chk("rst_drain_data", sq.drain_data, 0);
      chk("rst_qout_strb", sq.qout_strb, 0);
      chk("rst_qout_data", sq.qout_data, 0);

      // commit with nothing uncommitted must not bank a credit
      sq.cmt_en = 1'b1;
      tick();
      sq.cmt_en = 1'b0;
      set_enq(LSWIDTH_WORD, 32'h10, 32'h1);
      tick();
      sq.enq_valid = 1'b0;
      chk("cmt_empty_ignored", sq.cmt_valid, 1);
      chk("cmt_empty_dv", sq.drain_valid, 0);
      sq.cmt_en = 1'b1;
      tick();
      sq.cmt_en = 1'b0;
      drain_one("cmt_empty_drain", 32'h1);

      foreach (tbl[i]) begin
         set_enq(tbl[i].w, tbl[i].a, tbl[i].d);
         tick();
         sq.enq_valid = 1'b0;
         chk("vec_count", sq.count, 1);
         chk("vec_dv_precommit", sq.drain_valid, 0);
         sq.cmt_en = 1'b1;
         tick();
         sq.cmt_en = 1'b0;
         chk("vec_dv", sq.drain_valid, 1);
         chk("vec_strb", sq.drain_strb, tbl[i].strb);
         chk("vec_data", sq.drain_data, tbl[i].data);
         chk("vec_lswidth", sq.drain_lswidth, tbl[i].w);
         chk("vec_addr", sq.drain_addr, tbl[i].a);
         sq.drain_ready = 1'b1;
         tick();
         sq.drain_ready = 1'b0;
         chk("vec_count_after", sq.count, 0);
      end

      // fill to DEPTH, try a 9th, then drain while enqueue is held
      for (int i = 0; i < DEPTH; i++) begin
         set_enq(LSWIDTH_WORD, 32'h100 + 32'(4*i), 32'h100 + 32'(i));
         tick();
      end
      chk("full_enq_ready", sq.enq_ready, 0);
      chk("full_count", sq.count, DEPTH);
      sq.enq_data = 32'hBAD;
      tick();
      sq.enq_valid = 1'b0;
      chk("full_9th_ignored", sq.count, DEPTH);
      sq.cmt_en = 1'b1;
      repeat (DEPTH) tick();
      sq.cmt_en = 1'b0;
      chk("full_all_committed", sq.cmt_valid, 0);
      set_enq(LSWIDTH_WORD, 32'h200, 32'h99);
      sq.drain_ready = 1'b1;
      tick();
      sq.drain_ready = 1'b0;
      chk("full_drain_enq_dropped", sq.count, DEPTH - 1);
      chk("full_ready_back", sq.enq_ready, 1);
      tick();
      sq.enq_valid = 1'b0;
      chk("full_refill", sq.count, DEPTH);
      sq.cmt_en = 1'b1;
      tick();
      sq.cmt_en = 1'b0;
      for (int i = 1; i < DEPTH; i++) drain_one("full_order", 32'h100 + 32'(i));
      drain_one("full_last", 32'h99);
      chk("full_empty", sq.count, 0);

      // flush with a same-cycle commit and a dropped enqueue
      set_enq(LSWIDTH_WORD, 32'h300, 32'hA0); tick();
      set_enq(LSWIDTH_WORD, 32'h304, 32'hB0); tick();
      set_enq(LSWIDTH_WORD, 32'h308, 32'hC0); tick();
      sq.enq_valid = 1'b0;
      sq.cmt_en = 1'b1;
      tick();
      set_enq(LSWIDTH_WORD, 32'h30C, 32'hD0);
      sq.bco_valid = 1'b1;
      tick();
      sq.enq_valid = 1'b0;
      sq.bco_valid = 1'b0;
      sq.cmt_en    = 1'b0;
      chk("flush_count", sq.count, 2);
      chk("flush_cmt_valid", sq.cmt_valid, 0);
      tick();
      chk("flush_count_hold", sq.count, 2);
      drain_one("flush_a", 32'hA0);
      drain_one("flush_b", 32'hB0);
      chk("flush_dv_empty", sq.drain_valid, 0);
      chk("flush_empty", sq.count, 0);

      // forwarding: word then half, query latency and same-cycle exclusion
      set_enq(LSWIDTH_WORD, 32'h2000, 32'h1122_3344);
      sq.q_addr = 32'h2004;
      tick();
      set_enq(LSWIDTH_HALF, 32'h2002, 32'h0000_BEEF);
      sq.q_addr = 32'h2000;
      tick();
      sq.enq_valid = 1'b0;
      chk("fwd_old_strb", sq.qout_strb, FWD ? 4'b1111 : 4'b0000);
      chk("fwd_old_data", sq.qout_data, FWD ? 32'h1122_3344 : 32'h0);
      tick();
      chk("fwd_strb", sq.qout_strb, FWD ? 4'b1111 : 4'b0000);
      chk("fwd_data", sq.qout_data, FWD ? 32'hBEEF_3344 : 32'h0);
      sq.cmt_en = 1'b1;
      repeat (2) tick();
      sq.cmt_en = 1'b0;
      chk("fwd_committed_data", sq.qout_data, FWD ? 32'hBEEF_3344 : 32'h0);
      sq.q_addr = 32'h2004;
      tick();
      chk("fwd_miss_strb", sq.qout_strb, 0);
      chk("fwd_miss_data", sq.qout_data, 0);
      drain_one("fwd_drain_w", 32'h1122_3344);
      drain_one("fwd_drain_h", 32'hBEEF_BEEF);

      // uncached stores never forward
      set_enq(LSWIDTH_WORD, 32'h3000, 32'hDEAD_BEEF);
      sq.enq_uncached = 1'b1;
      sq.q_addr = 32'h3000;
      tick();
      sq.enq_valid    = 1'b0;
      sq.enq_uncached = 1'b0;
      tick();
      chk("unc_qout_strb", sq.qout_strb, 0);
      sq.cmt_en = 1'b1;
      tick();
      sq.cmt_en = 1'b0;
      chk("unc_drain_uncached", sq.drain_uncached, 1);
      chk("unc_drain_addr", sq.drain_addr, 32'h3000);
      drain_one("unc_drain", 32'hDEAD_BEEF);

      // pointer wrap against an order model
      ncmt = 0;
      for (int i = 0; i < 40; i++) begin
         bit ev, ce, dr, ea, ca, da;
         if (i < 24) begin
            ev = (i % 4 != 3);
            ce = (i % 3 != 0);
            dr = (i % 2 == 1);
         end else begin
            ev = 1'b0;
            ce = 1'b1;
            dr = 1'b1;
         end
         chk("wrap_count", sq.count, mdl.size());
         chk("wrap_le_depth", sq.count <= DEPTH, 1);
         chk("wrap_dv", sq.drain_valid, ncmt > 0);
         if (ncmt > 0) chk("wrap_data", sq.drain_data, mdl[0]);
         ea = ev && (mdl.size() < DEPTH);
         ca = ce && (mdl.size() - ncmt > 0);
         da = dr && (ncmt > 0);
         sq.enq_valid = ev;
         sq.enq_lswidth = LSWIDTH_WORD;
         sq.enq_addr = 32'h5000 + 32'(4*i);
         sq.enq_data = 32'hC000_0000 + 32'(i);
         sq.cmt_en = ce;
         sq.drain_ready = dr;
         tick();
         if (da) begin
            void'(mdl.pop_front());
            ncmt--;
         end
         if (ca) ncmt++;
         if (ea) mdl.push_back(32'hC000_0000 + 32'(i));
      end
      idle();
      chk("wrap_final_empty", sq.count, 0);
      chk("wrap_model_empty", mdl.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
